// File: rtl/datapath_bus.sv
// Shared 32-bit datapath bus: 24 request lines pick one source by fixed priority
// (R0 highest, C lowest) and the selected value is registered onto Bus_Mux_out.
module datapath_bus #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] R0_mux,
  input  logic [DATA_WIDTH-1:0] R1_mux,
  input  logic [DATA_WIDTH-1:0] R2_mux,
  input  logic [DATA_WIDTH-1:0] R3_mux,
  input  logic [DATA_WIDTH-1:0] R4_mux,
  input  logic [DATA_WIDTH-1:0] R5_mux,
  input  logic [DATA_WIDTH-1:0] R6_mux,
  input  logic [DATA_WIDTH-1:0] R7_mux,
  input  logic [DATA_WIDTH-1:0] R8_mux,
  input  logic [DATA_WIDTH-1:0] R9_mux,
  input  logic [DATA_WIDTH-1:0] R10_mux,
  input  logic [DATA_WIDTH-1:0] R11_mux,
  input  logic [DATA_WIDTH-1:0] R12_mux,
  input  logic [DATA_WIDTH-1:0] R13_mux,
  input  logic [DATA_WIDTH-1:0] R14_mux,
  input  logic [DATA_WIDTH-1:0] R15_mux,
  input  logic [DATA_WIDTH-1:0] PC_mux,
  input  logic [DATA_WIDTH-1:0] MDR_mux,
  input  logic [DATA_WIDTH-1:0] InPort_mux,
  input  logic [DATA_WIDTH-1:0] HI_mux,
  input  logic [DATA_WIDTH-1:0] LO_mux,
  input  logic [DATA_WIDTH-1:0] ZHI_mux,
  input  logic [DATA_WIDTH-1:0] ZLO_mux,
  input  logic [DATA_WIDTH-1:0] C_mux,
  input  logic                  R0_select,
  input  logic                  R1_select,
  input  logic                  R2_select,
  input  logic                  R3_select,
  input  logic                  R4_select,
  input  logic                  R5_select,
  input  logic                  R6_select,
  input  logic                  R7_select,
  input  logic                  R8_select,
  input  logic                  R9_select,
  input  logic                  R10_select,
  input  logic                  R11_select,
  input  logic                  R12_select,
  input  logic                  R13_select,
  input  logic                  R14_select,
  input  logic                  R15_select,
  input  logic                  PC_select,
  input  logic                  MDR_select,
  input  logic                  InPort_select,
  input  logic                  HI_select,
  input  logic                  LO_select,
  input  logic                  ZHI_select,
  input  logic                  ZLO_select,
  input  logic                  C_select,
  output logic [DATA_WIDTH-1:0] Bus_Mux_out
);

  localparam logic [4:0] IDLE_CODE = 5'd31;

  logic [23:0]           sel_s;
  logic [4:0]            code_s;
  logic [DATA_WIDTH-1:0] mux_s;
  logic [DATA_WIDTH-1:0] bus_d;
  logic [DATA_WIDTH-1:0] bus_q;

  // Scanning from the lowest-priority bit upward lets the lowest asserted index win.
  function automatic logic [4:0] prio_encode(input logic [23:0] sel);
    logic [4:0] code;
    code = IDLE_CODE;
    for (int i = 23; i >= 0; i--) begin
      if (sel[i]) begin
        code = i[4:0];
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

  // Gather the request lines; bit index equals source code.
  always_comb begin
    sel_s = {C_select,   ZLO_select, ZHI_select, LO_select,
             HI_select,  InPort_select, MDR_select, PC_select,
             R15_select, R14_select, R13_select, R12_select,
             R11_select, R10_select, R9_select,  R8_select,
             R7_select,  R6_select,  R5_select,  R4_select,
             R3_select,  R2_select,  R1_select,  R0_select};
  end

  // Priority encoder to the 5-bit source code.
  always_comb begin
    code_s = prio_encode(sel_s);
  end

  // Source mux; only the chosen source's data reaches the bus, so unselected X cannot leak.
  always_comb begin
    mux_s = {DATA_WIDTH{1'b0}};
    case (code_s)
      5'd0:    mux_s = R0_mux;
      5'd1:    mux_s = R1_mux;
      5'd2:    mux_s = R2_mux;
      5'd3:    mux_s = R3_mux;
      5'd4:    mux_s = R4_mux;
      5'd5:    mux_s = R5_mux;
      5'd6:    mux_s = R6_mux;
      5'd7:    mux_s = R7_mux;
      5'd8:    mux_s = R8_mux;
      5'd9:    mux_s = R9_mux;
      5'd10:   mux_s = R10_mux;
      5'd11:   mux_s = R11_mux;
      5'd12:   mux_s = R12_mux;
      5'd13:   mux_s = R13_mux;
      5'd14:   mux_s = R14_mux;
      5'd15:   mux_s = R15_mux;
      5'd16:   mux_s = PC_mux;
      5'd17:   mux_s = MDR_mux;
      5'd18:   mux_s = InPort_mux;
      5'd19:   mux_s = HI_mux;
      5'd20:   mux_s = LO_mux;
      5'd21:   mux_s = ZHI_mux;
      5'd22:   mux_s = ZLO_mux;
      5'd23:   mux_s = C_mux;
      default: mux_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Next bus value.
  always_comb begin
    bus_d = mux_s;
  end

  // Bus register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus_q <= {DATA_WIDTH{1'b0}};
    end else begin
      bus_q <= bus_d;
    end
  end

  assign Bus_Mux_out = bus_q;

endmodule

// File: tb/tb_datapath_bus.sv
// Directed bench for datapath_bus: a priority-scan model checked every negedge,
// plus literal expectations for reset, sweep, priority, hold and async clear.
module tb_datapath_bus;

  logic        clk;
  logic        clr;
  logic [31:0] src [24];
  logic        sel [24];
  logic [31:0] bus_out;
  logic [31:0] exp_q;
  int          total;
  int          bad;

  datapath_bus #(.DATA_WIDTH(32)) dut (
    .clk(clk), .clr(clr),
    .R0_mux(src[0]),   .R1_mux(src[1]),   .R2_mux(src[2]),   .R3_mux(src[3]),
    .R4_mux(src[4]),   .R5_mux(src[5]),   .R6_mux(src[6]),   .R7_mux(src[7]),
    .R8_mux(src[8]),   .R9_mux(src[9]),   .R10_mux(src[10]), .R11_mux(src[11]),
    .R12_mux(src[12]), .R13_mux(src[13]), .R14_mux(src[14]), .R15_mux(src[15]),
    .PC_mux(src[16]),  .MDR_mux(src[17]), .InPort_mux(src[18]), .HI_mux(src[19]),
    .LO_mux(src[20]),  .ZHI_mux(src[21]), .ZLO_mux(src[22]), .C_mux(src[23]),
    .R0_select(sel[0]),   .R1_select(sel[1]),   .R2_select(sel[2]),   .R3_select(sel[3]),
    .R4_select(sel[4]),   .R5_select(sel[5]),   .R6_select(sel[6]),   .R7_select(sel[7]),
    .R8_select(sel[8]),   .R9_select(sel[9]),   .R10_select(sel[10]), .R11_select(sel[11]),
    .R12_select(sel[12]), .R13_select(sel[13]), .R14_select(sel[14]), .R15_select(sel[15]),
    .PC_select(sel[16]),  .MDR_select(sel[17]), .InPort_select(sel[18]), .HI_select(sel[19]),
    .LO_select(sel[20]),  .ZHI_select(sel[21]), .ZLO_select(sel[22]), .C_select(sel[23]),
    .Bus_Mux_out(bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: first asserted source in list order wins, otherwise the bus is 0.
  function automatic logic [31:0] model_bus();
    for (int i = 0; i < 24; i++)
      if (sel[i] === 1'b1) return src[i];
    return 32'h0;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) exp_q <= 32'h0;
    else      exp_q <= model_bus();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic clear_sel();
    for (int i = 0; i < 24; i++) sel[i] = 1'b0;
  endtask

  // Drive a single select after an edge, then settle just past the following edge.
  task automatic apply_one(input int idx);
    @(posedge clk); #1;
    clear_sel();
    if (idx >= 0) sel[idx] = 1'b1;
    @(posedge clk); #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clr   = 1'b1;
    clear_sel();
    for (int i = 0; i < 16; i++) src[i] = 32'(i + 1);
    for (int k = 0; k < 8; k++) src[16 + k] = 32'(k + 1) * 32'h11111111;
    #1 clr = 1'b0;

    fork
      forever begin
        @(negedge clk);
        check("model", bus_out, exp_q);
      end
    join_none

    // Reset held while R0 is requested.
    sel[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #2;
      check("reset_hold", bus_out, 32'h0);
    end
    @(negedge clk); #1 clr = 1'b1;
    @(posedge clk); #2;
    check("reset_release", bus_out, 32'h00000001);

    for (int i = 0; i < 24; i++) begin
      apply_one(i);
      check("sweep", bus_out, src[i]);
      if (i == 5)  check("sweep_r5", bus_out, 32'h00000006);
      if (i == 23) check("sweep_c", bus_out, 32'h88888888);
    end

    apply_one(-1);
    check("idle", bus_out, 32'h0);

    @(posedge clk); #1;
    clear_sel(); sel[5] = 1'b1; sel[16] = 1'b1;
    @(posedge clk); #2;
    check("prio_r5_pc", bus_out, 32'h00000006);

    @(posedge clk); #1;
    clear_sel(); sel[19] = 1'b1; sel[23] = 1'b1;
    @(posedge clk); #2;
    check("prio_hi_c", bus_out, 32'h44444444);

    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) sel[i] = 1'b1;
    @(posedge clk); #2;
    check("prio_all", bus_out, 32'h00000001);

    // Mid-cycle data change must not reach the bus before the next edge.
    apply_one(5);
    check("hold_pre", bus_out, 32'h00000006);
    @(posedge clk); #3;
    src[5] = 32'hDEADBEEF;
    #1 check("hold_mid", bus_out, 32'h00000006);
    #4 check("hold_late", bus_out, 32'h00000006);
    @(posedge clk); #1;
    check("hold_update", bus_out, 32'hDEADBEEF);
    src[5] = 32'h00000006;

    // Asynchronous clear between edges.
    apply_one(23);
    check("async_pre", bus_out, 32'h88888888);
    @(posedge clk); #3;
    check("async_before", bus_out, 32'h88888888);
    clr = 1'b0;
    #1 check("async_clear", bus_out, 32'h0);
    #2 clr = 1'b1;
    #1 check("async_wait", bus_out, 32'h0);
    @(posedge clk); #2;
    check("async_resume", bus_out, 32'h88888888);

    apply_one(-1);
    check("idle_end", bus_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
